// File: rtl/qam_modulator_4qam_pkg.sv
// Shared 4QAM constants for the OTFS modulator and demodulator: symbol codes,
// default amplitude, modulator state encoding and the demodulator sign decision.
package qam_modulator_4qam_pkg;

   // Symbol codes named by the sign of (Re, Im): N = negative, P = positive
   localparam logic [1:0] QAM4_SYM_NP = 2'b00;
   localparam logic [1:0] QAM4_SYM_NN = 2'b01;
   localparam logic [1:0] QAM4_SYM_PP = 2'b10;
   localparam logic [1:0] QAM4_SYM_PN = 2'b11;

   localparam logic signed [23:0] QAM4_DEFAULT_AMP = 24'sd1448;

   typedef enum logic [1:0] {
      MOD_IDLE  = 2'd0,
      MOD_SHIFT = 2'd1,
      MOD_PAD   = 2'd2
   } mod_state_t;

   // Demodulator-side hard decision; exact inverse of the modulator mapping
   function automatic logic [1:0] qam4_demod_decision(input logic signed [23:0] re,
                                                      input logic signed [23:0] im);
      logic [1:0] code;
      if (re < 0) begin
         code = (im >= 0) ? QAM4_SYM_NP : QAM4_SYM_NN;
      end else begin
         code = (im >= 0) ? QAM4_SYM_PP : QAM4_SYM_PN;
      end
      return code;
   endfunction

endpackage

// File: rtl/qam4_symbol_map.sv
// Combinational 4QAM mapper: 2-bit symbol code to signed I/Q at amplitude amp.
module qam4_symbol_map
   import qam_modulator_4qam_pkg::*;
(
   input  logic [1:0]         sym_code,
   input  logic signed [23:0] amp,
   output logic signed [23:0] sym_re,
   output logic signed [23:0] sym_im
);

   // Sign pattern chosen per code so the demodulator decision inverts it exactly
   always_comb begin
      sym_re = amp;
      sym_im = amp;
      case (sym_code)
         QAM4_SYM_NP: begin sym_re = -amp; sym_im =  amp; end
         QAM4_SYM_NN: begin sym_re = -amp; sym_im = -amp; end
         QAM4_SYM_PP: begin sym_re =  amp; sym_im =  amp; end
         default:     begin sym_re =  amp; sym_im = -amp; end
      endcase
   end

endmodule

// File: rtl/qam_modulator_4qam.sv
// 4QAM modulator for OTFS transmit: bytes in, one I/Q symbol per handshake out,
// with frame First/Last flags and padding of partial frames at packet end.
module qam_modulator_4qam
   import qam_modulator_4qam_pkg::*;
#(
   parameter int               FRAME_LEN = 64,
   parameter logic signed [23:0] AMP     = QAM4_DEFAULT_AMP,
   parameter logic [1:0]       PAD_SYM   = 2'b00
)
(
   input  logic               Clk,
   input  logic               Rst,
   input  logic               QAMModDataValid,
   input  logic [7:0]         QAMModData,
   input  logic               QAMModLast,
   output logic               QAMModDataReady,
   output logic               OTFSTxModValid,
   input  logic               OTFSTxModReady,
   output logic signed [23:0] OTFSTxModRe,
   output logic signed [23:0] OTFSTxModIm,
   output logic               OTFSTxModFirst,
   output logic               OTFSTxModLast
);

   localparam int              CNT_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN - 1);

   mod_state_t         state_q, state_d;
   logic [7:0]         byte_q, byte_d;
   logic [1:0]         idx_q, idx_d;
   logic               pkt_last_q, pkt_last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               valid_q, valid_d;
   logic signed [23:0] re_q, re_d;
   logic signed [23:0] im_q, im_d;
   logic               first_q, first_d;
   logic               last_q, last_d;

   logic               out_hs;
   logic               in_hs;
   logic               frame_end;
   logic               pad_needed;
   logic               ready_int;
   logic               emit;
   logic [1:0]         sym_code;
   logic signed [23:0] map_re;
   logic signed [23:0] map_im;

   assign out_hs     = valid_q & OTFSTxModReady;
   assign frame_end  = (cnt_q == CNT_MAX);
   assign pad_needed = pkt_last_q & ~frame_end;
   assign in_hs      = QAMModDataValid & QAMModDataReady;

   // Input ready: free in IDLE, or in SHIFT exactly when the held byte retires without padding
   always_comb begin
      ready_int = 1'b0;
      case (state_q)
         MOD_IDLE:  ready_int = 1'b1;
         MOD_SHIFT: ready_int = out_hs & (idx_q == 2'd3) & ~pad_needed;
         default:   ready_int = 1'b0;
      endcase
   end

   assign QAMModDataReady = ready_int & ~Rst;

   // Next-state logic: pick the symbol to present next and update frame position
   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      idx_d      = idx_q;
      pkt_last_d = pkt_last_q;
      cnt_d      = cnt_q;
      valid_d    = valid_q;
      re_d       = re_q;
      im_d       = im_q;
      first_d    = first_q;
      last_d     = last_q;
      emit       = 1'b0;
      sym_code   = PAD_SYM;

      if (out_hs) begin
         cnt_d = frame_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         MOD_IDLE: begin
            if (in_hs) begin
               state_d    = MOD_SHIFT;
               byte_d     = QAMModData;
               idx_d      = 2'd0;
               pkt_last_d = QAMModLast;
               sym_code   = QAMModData[7:6];
               emit       = 1'b1;
            end
         end
         MOD_SHIFT: begin
            if (out_hs) begin
               if (idx_q != 2'd3) begin
                  idx_d = idx_q + 2'd1;
                  emit  = 1'b1;
                  case (idx_q)
                     2'd0:    sym_code = byte_q[5:4];
                     2'd1:    sym_code = byte_q[3:2];
                     default: sym_code = byte_q[1:0];
                  endcase
               end else if (pad_needed) begin
                  state_d  = MOD_PAD;
                  sym_code = PAD_SYM;
                  emit     = 1'b1;
               end else if (in_hs) begin
                  byte_d     = QAMModData;
                  idx_d      = 2'd0;
                  pkt_last_d = QAMModLast;
                  sym_code   = QAMModData[7:6];
                  emit       = 1'b1;
               end else begin
                  state_d = MOD_IDLE;
                  valid_d = 1'b0;
                  first_d = 1'b0;
                  last_d  = 1'b0;
               end
            end
         end
         default: begin
            if (out_hs) begin
               if (frame_end) begin
                  state_d    = MOD_IDLE;
                  pkt_last_d = 1'b0;
                  valid_d    = 1'b0;
                  first_d    = 1'b0;
                  last_d     = 1'b0;
               end else begin
                  sym_code = PAD_SYM;
                  emit     = 1'b1;
               end
            end
         end
      endcase

      if (emit) begin
         valid_d = 1'b1;
         re_d    = map_re;
         im_d    = map_im;
         first_d = (cnt_d == '0);
         last_d  = (cnt_d == CNT_MAX);
      end
   end

   qam4_symbol_map u_map (
      .sym_code (sym_code),
      .amp      (AMP),
      .sym_re   (map_re),
      .sym_im   (map_im)
   );

   // State and registered outputs; reset discards any held byte and partial frame
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= MOD_IDLE;
         byte_q     <= '0;
         idx_q      <= '0;
         pkt_last_q <= 1'b0;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         re_q       <= '0;
         im_q       <= '0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_q     <= byte_d;
         idx_q      <= idx_d;
         pkt_last_q <= pkt_last_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         re_q       <= re_d;
         im_q       <= im_d;
         first_q    <= first_d;
         last_q     <= last_d;
      end
   end

   assign OTFSTxModValid = valid_q;
   assign OTFSTxModRe    = re_q;
   assign OTFSTxModIm    = im_q;
   assign OTFSTxModFirst = first_q;
   assign OTFSTxModLast  = last_q;

endmodule

// File: tb/tb_qam_modulator_4qam.sv
// Scoreboard bench for the 4QAM modulator with an 8-symbol frame.
module tb_qam_modulator_4qam;

   localparam int FL = 8;
   localparam logic signed [23:0] A = 24'sd1448;

   logic               Clk = 1'b0;
   logic               Rst;
   logic               QAMModDataValid;
   logic [7:0]         QAMModData;
   logic               QAMModLast;
   logic               QAMModDataReady;
   logic               OTFSTxModValid;
   logic               OTFSTxModReady;
   logic signed [23:0] OTFSTxModRe;
   logic signed [23:0] OTFSTxModIm;
   logic               OTFSTxModFirst;
   logic               OTFSTxModLast;

   typedef struct packed {
      logic signed [23:0] re;
      logic signed [23:0] im;
      logic               first;
      logic               last;
      logic [1:0]         code;
   } sym_t;

   sym_t exp_q[$];
   int   m_cnt  = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   always #5 Clk = ~Clk;

   qam_modulator_4qam #(
      .FRAME_LEN (FL),
      .AMP       (A),
      .PAD_SYM   (2'b00)
   ) dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .QAMModDataValid (QAMModDataValid),
      .QAMModData      (QAMModData),
      .QAMModLast      (QAMModLast),
      .QAMModDataReady (QAMModDataReady),
      .OTFSTxModValid  (OTFSTxModValid),
      .OTFSTxModReady  (OTFSTxModReady),
      .OTFSTxModRe     (OTFSTxModRe),
      .OTFSTxModIm     (OTFSTxModIm),
      .OTFSTxModFirst  (OTFSTxModFirst),
      .OTFSTxModLast   (OTFSTxModLast)
   );

   // Reference constellation table, written out from the code/sign list
   function automatic sym_t ref_sym(input logic [1:0] c, input int pos);
      sym_t s;
      case (c)
         2'd0:    begin s.re = -A; s.im =  A; end
         2'd1:    begin s.re = -A; s.im = -A; end
         2'd2:    begin s.re =  A; s.im =  A; end
         default: begin s.re =  A; s.im = -A; end
      endcase
      s.first = (pos == 0);
      s.last  = (pos == FL - 1);
      s.code  = c;
      return s;
   endfunction

   // Loopback sign-decision demodulator
   function automatic logic [1:0] demod(input logic signed [23:0] re, input logic signed [23:0] im);
      return {(re > 0), (im < 0)};
   endfunction

   // Scoreboard push for an accepted byte, including any trailing pad symbols
   function automatic void push_byte(input logic [7:0] data, input logic last);
      logic [7:0] d;
      d = data;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(ref_sym(d[7:6], m_cnt));
         d = d << 2;
         m_cnt = (m_cnt + 1) % FL;
      end
      if (last) begin
         while (m_cnt != 0) begin
            exp_q.push_back(ref_sym(2'b00, m_cnt));
            m_cnt = (m_cnt + 1) % FL;
         end
      end
   endfunction

   // One cycle: sample handshakes just after inputs settle, update scoreboard, advance to next negedge
   task automatic step(output bit in_hs, output bit out_hs, output bit vld, output bit rdy,
                       output sym_t obs, output sym_t exp, output bit exp_ok);
      #1;
      vld    = OTFSTxModValid;
      rdy    = QAMModDataReady;
      out_hs = OTFSTxModValid && OTFSTxModReady && !Rst;
      in_hs  = QAMModDataValid && QAMModDataReady && !Rst;
      obs.re    = OTFSTxModRe;
      obs.im    = OTFSTxModIm;
      obs.first = OTFSTxModFirst;
      obs.last  = OTFSTxModLast;
      obs.code  = demod(OTFSTxModRe, OTFSTxModIm);
      exp    = '0;
      exp_ok = 1'b1;
      if (out_hs) begin
         if (exp_q.size() > 0) exp = exp_q.pop_front();
         else exp_ok = 1'b0;
      end
      if (in_hs) push_byte(QAMModData, QAMModLast);
      @(negedge Clk);
   endtask

   task automatic test_reset();
      bit ih, oh, v, r, ok;
      sym_t o, e;
      Rst = 1'b1;
      QAMModDataValid = 1'b1;
      QAMModData = 8'hC3;
      QAMModLast = 1'b0;
      step(ih, oh, v, r, o, e, ok);
      step(ih, oh, v, r, o, e, ok);
      n_cmp++; if (v !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b want 0", v); end
      n_cmp++; if (o.re !== 24'sd0 || o.im !== 24'sd0) begin n_bad++; $display("[TB] FAIL reset_iq: got re=%0d im=%0d want 0 0", o.re, o.im); end
      n_cmp++; if (o.first !== 1'b0 || o.last !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_flags: got first=%b last=%b want 0 0", o.first, o.last); end
      n_cmp++; if (r !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ready: got %b want 0", r); end
      Rst = 1'b0;
      QAMModDataValid = 1'b0;
      QAMModData = 8'h5A;
      step(ih, oh, v, r, o, e, ok);
      n_cmp++; if (r !== 1'b1 || v !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_after_reset: got ready=%b valid=%b want 1 0", r, v); end
   endtask

   task automatic test_single_byte();
      bit ih, oh, v, r, ok;
      sym_t o, e;
      int idx = 0, k = 0, acc_c = -1, c0 = -1, c3 = -1;
      for (int c = 0; c < 100; c++) begin
         QAMModDataValid = (idx < 1);
         QAMModData = (idx < 1) ? 8'h1B : 8'h5A;
         QAMModLast = (idx < 1);
         step(ih, oh, v, r, o, e, ok);
         if (ih) begin idx++; acc_c = c; end
         if (oh) begin
            n_cmp++;
            if (!ok || o !== e) begin n_bad++; $display("[TB] FAIL single_sym%0d: got re=%0d im=%0d f=%b l=%b want re=%0d im=%0d f=%b l=%b", k, o.re, o.im, o.first, o.last, e.re, e.im, e.first, e.last); end
            if (k == 0) c0 = c;
            if (k == 3) c3 = c;
            k++;
         end
         if (idx == 1 && exp_q.size() == 0) break;
      end
      n_cmp++; if (idx != 1 || exp_q.size() != 0) begin n_bad++; $display("[TB] FAIL single_drain: got accepted=%0d pending=%0d want 1 0", idx, exp_q.size()); end
      n_cmp++; if (c0 - acc_c != 1) begin n_bad++; $display("[TB] FAIL single_latency: got %0d want 1", c0 - acc_c); end
      n_cmp++; if (c3 - c0 != 3) begin n_bad++; $display("[TB] FAIL single_spacing: got %0d want 3", c3 - c0); end
   endtask

   task automatic test_back_to_back();
      bit ih, oh, v, r, ok;
      sym_t o, e;
      logic [7:0] b [2];
      int idx = 0, k = 0, c0 = -1, c7 = -1;
      b[0] = 8'hFF; b[1] = 8'h00;
      for (int c = 0; c < 100; c++) begin
         QAMModDataValid = (idx < 2);
         QAMModData = (idx < 2) ? b[idx] : 8'h5A;
         QAMModLast = (idx == 1);
         step(ih, oh, v, r, o, e, ok);
         if (ih) idx++;
         if (oh) begin
            n_cmp++;
            if (!ok || o !== e) begin n_bad++; $display("[TB] FAIL b2b_sym%0d: got re=%0d im=%0d f=%b l=%b want re=%0d im=%0d f=%b l=%b", k, o.re, o.im, o.first, o.last, e.re, e.im, e.first, e.last); end
            if (k == 0) c0 = c;
            if (k == 7) c7 = c;
            k++;
         end
         if (idx == 2 && exp_q.size() == 0) break;
      end
      n_cmp++; if (idx != 2 || k != 8) begin n_bad++; $display("[TB] FAIL b2b_count: got bytes=%0d syms=%0d want 2 8", idx, k); end
      n_cmp++; if (c7 - c0 != 7) begin n_bad++; $display("[TB] FAIL b2b_bubble: got span=%0d want 7", c7 - c0); end
      QAMModDataValid = 1'b0;
      step(ih, oh, v, r, o, e, ok);
      n_cmp++; if (r !== 1'b1 || v !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_idle: got ready=%b valid=%b want 1 0", r, v); end
   endtask

   task automatic test_pad();
      bit ih, oh, v, r, ok;
      sym_t o, e;
      int idx = 0, k = 0;
      for (int c = 0; c < 100; c++) begin
         QAMModDataValid = (idx < 1);
         QAMModData = (idx < 1) ? 8'hAA : 8'h5A;
         QAMModLast = (idx < 1);
         step(ih, oh, v, r, o, e, ok);
         if (ih) idx++;
         if (v && k >= 3 && k <= 7) begin
            n_cmp++;
            if (r !== 1'b0) begin n_bad++; $display("[TB] FAIL pad_ready_sym%0d: got %b want 0", k, r); end
         end
         if (oh) begin
            n_cmp++;
            if (!ok || o !== e) begin n_bad++; $display("[TB] FAIL pad_sym%0d: got re=%0d im=%0d f=%b l=%b want re=%0d im=%0d f=%b l=%b", k, o.re, o.im, o.first, o.last, e.re, e.im, e.first, e.last); end
            k++;
         end
         if (idx == 1 && exp_q.size() == 0) break;
      end
      n_cmp++; if (k != 8) begin n_bad++; $display("[TB] FAIL pad_count: got %0d want 8", k); end
      QAMModDataValid = 1'b0;
      step(ih, oh, v, r, o, e, ok);
      n_cmp++; if (r !== 1'b1 || v !== 1'b0) begin n_bad++; $display("[TB] FAIL pad_idle: got ready=%b valid=%b want 1 0", r, v); end
   endtask

   task automatic test_stall_loopback();
      bit ih, oh, v, r, ok, prev_stall = 0;
      sym_t o, e, held;
      logic [7:0] b [16];
      int idx = 0, k = 0;
      held = '0;
      for (int i = 0; i < 16; i++) b[i] = 8'($urandom_range(0, 255));
      for (int c = 0; c < 2000; c++) begin
         QAMModDataValid = (idx < 16) && ($urandom_range(0, 3) != 0);
         QAMModData = QAMModDataValid ? b[idx] : 8'($urandom_range(0, 255));
         QAMModLast = (idx == 15);
         OTFSTxModReady = ($urandom_range(0, 1) == 1);
         step(ih, oh, v, r, o, e, ok);
         if (prev_stall) begin
            n_cmp++;
            if (!v || o !== held) begin n_bad++; $display("[TB] FAIL stall_hold: got v=%b re=%0d im=%0d f=%b l=%b want v=1 re=%0d im=%0d f=%b l=%b", v, o.re, o.im, o.first, o.last, held.re, held.im, held.first, held.last); end
         end
         prev_stall = v && !OTFSTxModReady;
         held = o;
         if (ih) idx++;
         if (oh) begin
            n_cmp++;
            if (!ok || o !== e) begin n_bad++; $display("[TB] FAIL loop_sym%0d: got code=%0d re=%0d im=%0d f=%b l=%b want code=%0d re=%0d im=%0d f=%b l=%b", k, o.code, o.re, o.im, o.first, o.last, e.code, e.re, e.im, e.first, e.last); end
            k++;
         end
         if (idx == 16 && exp_q.size() == 0) break;
      end
      n_cmp++; if (idx != 16 || k != 64) begin n_bad++; $display("[TB] FAIL loop_count: got bytes=%0d syms=%0d want 16 64", idx, k); end
      OTFSTxModReady = 1'b1;
      QAMModDataValid = 1'b0;
   endtask

   task automatic test_reset_midframe();
      bit ih, oh, v, r, ok;
      sym_t o, e;
      logic [7:0] b [2];
      int idx = 0, k = 0;
      b[0] = 8'hE4; b[1] = 8'h1B;
      for (int c = 0; c < 100 && k < 2; c++) begin
         QAMModDataValid = (idx < 2);
         QAMModData = (idx < 2) ? b[idx] : 8'h5A;
         QAMModLast = 1'b0;
         step(ih, oh, v, r, o, e, ok);
         if (ih) idx++;
         if (oh) begin
            n_cmp++;
            if (!ok || o !== e) begin n_bad++; $display("[TB] FAIL prerst_sym%0d: got re=%0d im=%0d f=%b l=%b want re=%0d im=%0d f=%b l=%b", k, o.re, o.im, o.first, o.last, e.re, e.im, e.first, e.last); end
            k++;
         end
      end
      Rst = 1'b1;
      QAMModDataValid = 1'b1;
      QAMModData = 8'h77;
      step(ih, oh, v, r, o, e, ok);
      n_cmp++; if (r !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_ready: got %b want 0", r); end
      exp_q.delete();
      m_cnt = 0;
      Rst = 1'b0;
      QAMModDataValid = 1'b0;
      step(ih, oh, v, r, o, e, ok);
      n_cmp++; if (v !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_valid_drop: got %b want 0", v); end
      idx = 0; k = 0;
      for (int c = 0; c < 100; c++) begin
         QAMModDataValid = (idx < 1);
         QAMModData = (idx < 1) ? 8'h1B : 8'h5A;
         QAMModLast = (idx < 1);
         step(ih, oh, v, r, o, e, ok);
         if (ih) idx++;
         if (oh) begin
            n_cmp++;
            if (!ok || o !== e) begin n_bad++; $display("[TB] FAIL postrst_sym%0d: got re=%0d im=%0d f=%b l=%b want re=%0d im=%0d f=%b l=%b", k, o.re, o.im, o.first, o.last, e.re, e.im, e.first, e.last); end
            k++;
         end
         if (idx == 1 && exp_q.size() == 0) break;
      end
      n_cmp++; if (k != 8) begin n_bad++; $display("[TB] FAIL postrst_count: got %0d want 8", k); end
   endtask

   task automatic test_underrun();
      bit ih, oh, v, r, ok;
      sym_t o, e;
      logic [7:0] b [2];
      int k = 0;
      b[0] = 8'h12; b[1] = 8'h34;
      for (int j = 0; j < 2; j++) begin
         int idx = 0;
         for (int c = 0; c < 100; c++) begin
            QAMModDataValid = (idx < 1);
            QAMModData = (idx < 1) ? b[j] : 8'h5A;
            QAMModLast = (idx < 1) && (j == 1);
            step(ih, oh, v, r, o, e, ok);
            if (ih) idx++;
            if (oh) begin
               n_cmp++;
               if (!ok || o !== e) begin n_bad++; $display("[TB] FAIL gap_sym%0d: got re=%0d im=%0d f=%b l=%b want re=%0d im=%0d f=%b l=%b", k, o.re, o.im, o.first, o.last, e.re, e.im, e.first, e.last); end
               k++;
            end
            if (idx == 1 && exp_q.size() == 0) break;
         end
         if (j == 0) begin
            QAMModDataValid = 1'b0;
            for (int g = 0; g < 5; g++) begin
               QAMModData = 8'($urandom_range(0, 255));
               step(ih, oh, v, r, o, e, ok);
               n_cmp++;
               if (v !== 1'b0) begin n_bad++; $display("[TB] FAIL gap_valid%0d: got %b want 0", g, v); end
            end
         end
      end
      n_cmp++; if (k != 8 || exp_q.size() != 0) begin n_bad++; $display("[TB] FAIL gap_count: got syms=%0d pending=%0d want 8 0", k, exp_q.size()); end
      QAMModDataValid = 1'b0;
      step(ih, oh, v, r, o, e, ok);
      n_cmp++; if (r !== 1'b1 || v !== 1'b0) begin n_bad++; $display("[TB] FAIL gap_idle: got ready=%b valid=%b want 1 0", r, v); end
   endtask

   // Watchdog so the run always terminates
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Rst = 1'b1;
      QAMModDataValid = 1'b0;
      QAMModData = 8'h00;
      QAMModLast = 1'b0;
      OTFSTxModReady = 1'b1;
      @(negedge Clk);
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_pad();
      test_stall_loopback();
      test_reset_midframe();
      test_underrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
